fan_angle_tracker: RTL and testbench

- Upstream stage of the LED-fan frame generators (dance/walk frame modules and the frame-select FSM).
- Takes the raw once-per-revolution fan sensor pulse and measures the rotation period in clk cycles.
- Produces a column index plus a column strobe so frame modules can output the correct 16-bit LED column for each angular slot.
- Also flags whether the fan is actually spinning, so downstream logic can blank the LEDs when it is not.

---
 rtl/fan_pkg.sv | 15 +
 rtl/fanclk_sync_edge.sv | 38 +++
 rtl/fan_angle_tracker.sv | 127 ++++++++++++
 tb/tb_fan_angle_tracker.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// Shared constants and state encoding for the fan angle tracker and the
// frame modules that consume its column index.
package fan_pkg;

  localparam int DEF_NUM_COLS = 360;
  localparam int DEF_COL_W    = 9;
  localparam int DEF_PERIOD_W = 27;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    RUN     = 2'd2
  } fan_state_e;

endpackage

// File: rtl/fanclk_sync_edge.sv
// Two-flop synchronizer for the raw fan sensor followed by a registered
// rising-edge pulse; an edge on the pin shows up three clk cycles later.
module fanclk_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic fanclk,
  output logic edge_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic level_q, level_d;
  logic edge_q,  edge_d;

  always_comb begin
    sync1_d = fanclk;
    sync2_d = sync1_q;
    level_d = sync2_q;
    edge_d  = sync2_q & ~level_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      edge_q  <= edge_d;
    end
  end

  assign edge_pulse = edge_q;

endmodule

// File: rtl/fan_angle_tracker.sv
// Measures the fan revolution period from the once-per-turn sensor and
// divides each revolution into NUM_COLS column strobes for the frame logic.
module fan_angle_tracker
  import fan_pkg::*;
#(
  parameter int NUM_COLS   = DEF_NUM_COLS,
  parameter int COL_W      = DEF_COL_W,
  parameter int PERIOD_W   = DEF_PERIOD_W,
  parameter int MIN_PERIOD = 100000,
  parameter int TIMEOUT    = 100000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fanclk,
  output logic [COL_W-1:0]    col_idx,
  output logic                col_stb,
  output logic                rev_stb,
  output logic                spinning,
  output logic [PERIOD_W-1:0] period,
  output fan_state_e          state_dbg
);

  localparam int ACC_W = PERIOD_W + 1;

  logic fan_edge;

  fanclk_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .fanclk     (fanclk),
    .edge_pulse (fan_edge)
  );

  fan_state_e          state_q,   state_d;
  logic [PERIOD_W-1:0] cnt_q,     cnt_d;
  logic [ACC_W-1:0]    acc_q,     acc_d;
  logic [COL_W-1:0]    col_idx_q, col_idx_d;
  logic                col_stb_q, col_stb_d;
  logic                rev_stb_q, rev_stb_d;
  logic [PERIOD_W-1:0] period_q,  period_d;

  logic             cnt_max;
  logic             accept;
  logic [ACC_W-1:0] acc_sum;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    col_idx_d = col_idx_q;
    col_stb_d = 1'b0;
    rev_stb_d = 1'b0;
    period_d  = period_q;

    cnt_max = (cnt_q == PERIOD_W'(TIMEOUT - 1));
    cnt_d   = cnt_max ? cnt_q : cnt_q + 1'b1;
    // The first edge after idle has no reference, so the bounce filter only
    // applies once a measurement is under way.
    accept  = fan_edge &&
              ((state_q == IDLE) || (cnt_q >= PERIOD_W'(MIN_PERIOD - 1)));
    acc_sum = acc_q + ACC_W'(NUM_COLS);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end
      end
      CAPTURE, RUN: begin
        if (accept) begin
          state_d   = RUN;
          cnt_d     = '0;
          period_d  = cnt_q + 1'b1;
          acc_d     = '0;
          col_idx_d = '0;
          col_stb_d = 1'b1;
          rev_stb_d = 1'b1;
        end else if (cnt_max) begin
          state_d   = IDLE;
          acc_d     = '0;
          col_idx_d = '0;
          period_d  = '0;
        end else if (state_q == RUN) begin
          // Bresenham-style divide: one column every period/NUM_COLS cycles.
          if (acc_sum >= {1'b0, period_q}) begin
            acc_d = acc_sum - {1'b0, period_q};
            if (col_idx_q != COL_W'(NUM_COLS - 1)) begin
              col_idx_d = col_idx_q + 1'b1;
              col_stb_d = 1'b1;
            end
          end else begin
            acc_d = acc_sum;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      col_idx_q <= '0;
      col_stb_q <= 1'b0;
      rev_stb_q <= 1'b0;
      period_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      col_idx_q <= col_idx_d;
      col_stb_q <= col_stb_d;
      rev_stb_q <= rev_stb_d;
      period_q  <= period_d;
    end
  end

  assign col_idx   = col_idx_q;
  assign col_stb   = col_stb_q;
  assign rev_stb   = rev_stb_q;
  assign period    = period_q;
  assign spinning  = (state_q == RUN);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fan_angle_tracker.sv
// Directed bench for fan_angle_tracker: a table of sensor gaps with expected
// per-revolution results, plus hand-written stop, restart and reset sequences.
module tb_fan_angle_tracker;
  import fan_pkg::*;

  localparam int NC   = 36;
  localparam int CW   = 6;
  localparam int PW   = 27;
  localparam int MINP = 1000;
  localparam int TO   = 10000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fanclk = 1'b0;
  logic [CW-1:0] col_idx;
  logic          col_stb;
  logic          rev_stb;
  logic          spinning;
  logic [PW-1:0] period;
  fan_state_e    state_dbg;

  fan_angle_tracker #(
    .NUM_COLS   (NC),
    .COL_W      (CW),
    .PERIOD_W   (PW),
    .MIN_PERIOD (MINP),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fanclk    (fanclk),
    .col_idx   (col_idx),
    .col_stb   (col_stb),
    .rev_stb   (rev_stb),
    .spinning  (spinning),
    .period    (period),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: per-revolution column statistics, snapshotted on each rev_stb.
  int cyc = 0;
  int cols_cur = 0, min_cur = 999999, max_cur = 0, last_stb = 0, prev_idx = 0;
  int snap_cols = 0, snap_min = 0, snap_max = 0, snap_last = 0;
  int rev_total = 0, stb_total = 0, last_rev_cyc = 0, fall_cyc = 0;
  logic prev_spin = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (rev_stb) begin
          rev_total++;
          last_rev_cyc = cyc;
          snap_cols = cols_cur;
          snap_min  = min_cur;
          snap_max  = max_cur;
          snap_last = prev_idx;
          cols_cur  = col_stb ? 1 : 0;
          min_cur   = 999999;
          max_cur   = 0;
          last_stb  = cyc;
        end else if (col_stb) begin
          cols_cur++;
          if (cyc - last_stb < min_cur) min_cur = cyc - last_stb;
          if (cyc - last_stb > max_cur) max_cur = cyc - last_stb;
          last_stb = cyc;
        end
        if (col_stb) stb_total++;
        if (prev_spin && !spinning) fall_cyc = cyc;
      end
      prev_spin = spinning;
      prev_idx  = int'(col_idx);
    end
  end

  // Raise the sensor at a falling clk edge, hold 10 cycles, then idle out the gap.
  task automatic pulse_wait(input int gap);
    fanclk = 1'b1;
    repeat (10) @(negedge clk);
    fanclk = 1'b0;
    repeat (gap - 10) @(negedge clk);
  endtask

  typedef struct {
    int   gap;
    logic spin;
    int   per;
    int   revs;
    logic chk_rev;
    int   cols;
    int   mn;
    int   mx;
    int   last;
  } vec_t;

  vec_t vecs[10];
  int   base_stb;
  int   waited;

  initial begin
    // gap after this pulse; checks apply at the end of that gap
    vecs[0] = '{3600, 1'b0,    0, 0, 1'b0,  0,   0,   0,  0};
    vecs[1] = '{3600, 1'b1, 3600, 1, 1'b0,  0,   0,   0,  0};
    vecs[2] = '{  50, 1'b1, 3600, 2, 1'b1, 36, 100, 100, 35};
    vecs[3] = '{3550, 1'b1, 3600, 2, 1'b1, 36, 100, 100, 35};
    vecs[4] = '{3605, 1'b1, 3600, 3, 1'b1, 36, 100, 100, 35};
    vecs[5] = '{3605, 1'b1, 3605, 4, 1'b1, 36, 100, 100, 35};
    vecs[6] = '{4000, 1'b1, 3605, 5, 1'b1, 36, 100, 101, 35};
    vecs[7] = '{4000, 1'b1, 4000, 6, 1'b1, 36, 100, 101, 35};
    vecs[8] = '{2000, 1'b1, 4000, 7, 1'b1, 36, 111, 112, 35};
    vecs[9] = '{ 200, 1'b1, 2000, 8, 1'b1, 18, 111, 112, 17};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_col_idx", col_idx, 0);
    chk("rst_col_stb", col_stb, 0);
    chk("rst_rev_stb", rev_stb, 0);
    chk("rst_spinning", spinning, 0);
    chk("rst_period", period, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_state", state_dbg, IDLE);

    for (int i = 0; i < 10; i++) begin
      pulse_wait(vecs[i].gap);
      chk($sformatf("v%0d_spinning", i), spinning, vecs[i].spin);
      chk($sformatf("v%0d_period", i), period, vecs[i].per);
      chk($sformatf("v%0d_revs", i), rev_total, vecs[i].revs);
      if (vecs[i].chk_rev) begin
        chk($sformatf("v%0d_cols", i), snap_cols, vecs[i].cols);
        chk($sformatf("v%0d_min_sp", i), snap_min, vecs[i].mn);
        chk($sformatf("v%0d_max_sp", i), snap_max, vecs[i].mx);
        chk($sformatf("v%0d_last_idx", i), snap_last, vecs[i].last);
      end
    end

    // Stop: no more edges, spinning must fall TO cycles after the last rev_stb
    waited = 0;
    while (spinning && waited < TO + 100) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    chk("stop_spinning", spinning, 0);
    chk("stop_delay", fall_cyc - last_rev_cyc, TO);
    chk("stop_period", period, 0);
    chk("stop_col_idx", col_idx, 0);
    chk("stop_state", state_dbg, IDLE);
    base_stb = stb_total;
    repeat (200) @(negedge clk);
    chk("stop_no_col_stb", stb_total - base_stb, 0);

    // Restart: two edges 3600 apart bring it back to RUN
    pulse_wait(3600);
    chk("restart_capture_state", state_dbg, CAPTURE);
    chk("restart_capture_spin", spinning, 0);
    pulse_wait(100);
    chk("restart_spinning", spinning, 1);
    chk("restart_period", period, 3600);
    chk("restart_revs", rev_total, 9);

    // Reset mid-RUN while col_idx is part way through the revolution
    waited = 0;
    while (col_idx != CW'(20) && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    chk("midrun_reached_idx20", col_idx, 20);
    #2;
    rst = 1'b0;
    #1;
    chk("async_col_idx", col_idx, 0);
    chk("async_col_stb", col_stb, 0);
    chk("async_rev_stb", rev_stb, 0);
    chk("async_spinning", spinning, 0);
    chk("async_period", period, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("after_rst_state", state_dbg, IDLE);
    chk("after_rst_spinning", spinning, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
